// File: rtl/serial_plane_receiver.sv
// Deserialises {plane, 18 data bits} frames from the sen/sd link into 1-bit RB2 writes.
// Latency: one cycle from sd sample to rb2_*; no backpressure, a sen=1 cycle aborts the frame.
module serial_plane_receiver #(
  parameter int ADDR_BITS = 3,
  parameter int DATA_BITS = 18,
  parameter int IDX_W     = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       sen,
  input  logic                       sd,
  output logic                       rb2_we,
  output logic [ADDR_BITS+IDX_W-1:0] rb2_a,
  output logic                       rb2_d,
  output logic                       frame_done,
  output logic                       done
);

  localparam int BCNT_W = (ADDR_BITS > 1) ? $clog2(ADDR_BITS) : 1;
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(ADDR_BITS - 1);
  localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [ADDR_BITS-1:0]       r_hdr, w_hdr_nxt;
  logic [BCNT_W-1:0]          r_bcnt, w_bcnt_nxt;
  logic [IDX_W-1:0]           r_idx, w_idx_nxt;
  logic                       r_we, w_we_nxt;
  logic [ADDR_BITS+IDX_W-1:0] r_a, w_a_nxt;
  logic                       r_d, w_d_nxt;
  logic                       r_fd, w_fd_nxt;
  logic                       r_done, w_done_nxt;
  logic [ADDR_BITS-1:0]       w_hdr_shift;

  assign w_hdr_shift = ADDR_BITS'({r_hdr, sd});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hdr  <= '0;
      r_bcnt <= '0;
      r_idx  <= '0;
      r_we   <= 1'b0;
      r_a    <= '0;
      r_d    <= 1'b0;
      r_fd   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_hdr  <= w_hdr_nxt;
      r_bcnt <= w_bcnt_nxt;
      r_idx  <= w_idx_nxt;
      r_we   <= w_we_nxt;
      r_a    <= w_a_nxt;
      r_d    <= w_d_nxt;
      r_fd   <= w_fd_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hdr_nxt   = r_hdr;
    w_bcnt_nxt  = r_bcnt;
    w_idx_nxt   = r_idx;
    w_we_nxt    = 1'b0;
    w_a_nxt     = r_a;
    w_d_nxt     = r_d;
    w_fd_nxt    = 1'b0;
    w_done_nxt  = r_done;

    if (sen) begin
      // Idle or abort: drop any partial header/index so the next sen=0 starts clean.
      w_state_nxt = S_IDLE;
      w_hdr_nxt   = '0;
      w_bcnt_nxt  = '0;
      w_idx_nxt   = '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          w_hdr_nxt = ADDR_BITS'(sd);
          if (ADDR_BITS == 1) begin
            w_bcnt_nxt  = '0;
            w_idx_nxt   = IDX_FIRST;
            w_state_nxt = S_DATA;
          end else begin
            w_bcnt_nxt  = BCNT_W'(1);
            w_state_nxt = S_ADDR;
          end
        end
        S_ADDR: begin
          w_hdr_nxt = w_hdr_shift;
          if (r_bcnt == BCNT_LAST) begin
            w_bcnt_nxt  = '0;
            w_idx_nxt   = IDX_FIRST;
            w_state_nxt = S_DATA;
          end else begin
            w_bcnt_nxt = r_bcnt + BCNT_W'(1);
          end
        end
        S_DATA: begin
          w_we_nxt = 1'b1;
          w_a_nxt  = {r_hdr, r_idx};
          w_d_nxt  = sd;
          if (r_idx == '0) begin
            // Frames are back-to-back: the next sen=0 bit is already the next header MSB.
            w_fd_nxt    = 1'b1;
            w_bcnt_nxt  = '0;
            w_state_nxt = S_ADDR;
            if (&r_hdr) begin
              w_done_nxt = 1'b1;
            end
          end else begin
            w_idx_nxt = r_idx - IDX_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_hdr_nxt   = '0;
          w_bcnt_nxt  = '0;
          w_idx_nxt   = '0;
        end
      endcase
    end
  end

  assign rb2_we     = r_we;
  assign rb2_a      = r_a;
  assign rb2_d      = r_d;
  assign frame_done = r_fd;
  assign done       = r_done;

endmodule

// File: tb/tb_serial_plane_receiver.sv
// Drives frames on the falling edge and scores every RB2 write against a frame-level model.
module tb_serial_plane_receiver;

  logic       clk;
  logic       rst;
  logic       sen;
  logic       sd;
  logic       rb2_we;
  logic [7:0] rb2_a;
  logic       rb2_d;
  logic       frame_done;
  logic       done;

  serial_plane_receiver #(
    .ADDR_BITS(3),
    .DATA_BITS(18),
    .IDX_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sen(sen),
    .sd(sd),
    .rb2_we(rb2_we),
    .rb2_a(rb2_a),
    .rb2_d(rb2_d),
    .frame_done(frame_done),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic       d;
    logic       fd;
    logic       dn;
  } exp_t;

  exp_t exp_q[$];
  int   chk = 0;
  int   err = 0;
  int   n_wr = 0;
  int   n_fd = 0;
  logic model_done = 1'b0;
  logic cur_done = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] ex);
    chk++;
    assert (obs === ex) else begin
      err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, ex);
    end
  endtask

  // Every cycle: a write must match the head of the expected queue; otherwise no pulse.
  task automatic sample();
    exp_t e;
    if (rb2_we === 1'b1) begin
      n_wr++;
      if (frame_done === 1'b1) n_fd++;
      chk++;
      assert (exp_q.size() != 0) else begin
        err++;
        $error("FAIL unexpected_write observed=%0h expected=none", rb2_a);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        cur_done = e.dn;
        chk_eq("rb2_a", 32'(rb2_a), 32'(e.a));
        chk_eq("rb2_d", 32'(rb2_d), 32'(e.d));
        chk_eq("frame_done", 32'(frame_done), 32'(e.fd));
        chk_eq("done_wr", 32'(done), 32'(e.dn));
      end
    end else begin
      chk_eq("fd_nowrite", 32'(frame_done), 32'(0));
      chk_eq("done_nowrite", 32'(done), 32'(cur_done));
    end
  endtask

  task automatic cyc(input logic s, input logic d);
    @(negedge clk);
    sen = s;
    sd  = d;
    @(posedge clk);
    #1;
    sample();
  endtask

  // Sends the first `cut` sampled bits of a frame (21 = whole frame) and queues its writes.
  task automatic send_bits(input logic [2:0] p, input logic [17:0] dat, input int cut);
    exp_t e;
    int   nw;
    nw = (cut > 3) ? cut - 3 : 0;
    for (int i = 0; i < nw; i++) begin
      e.a  = {p, 5'(17 - i)};
      e.d  = dat[17 - i];
      e.fd = (cut == 21) && (i == 17);
      e.dn = model_done | (e.fd & (p == 3'd7));
      exp_q.push_back(e);
    end
    if (cut == 21 && p == 3'd7) model_done = 1'b1;
    for (int k = 0; k < cut; k++) begin
      if (k < 3) cyc(1'b0, p[2 - k]);
      else       cyc(1'b0, dat[20 - k]);
    end
  endtask

  task automatic send_frame(input logic [2:0] p, input logic [17:0] dat, input int cut);
    send_bits(p, dat, cut);
    if (cut < 21) cyc(1'b1, 1'($urandom));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'($urandom));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk_eq({tag, "_we"}, 32'(rb2_we), 32'(0));
    chk_eq({tag, "_a"}, 32'(rb2_a), 32'(0));
    chk_eq({tag, "_d"}, 32'(rb2_d), 32'(0));
    chk_eq({tag, "_fd"}, 32'(frame_done), 32'(0));
    chk_eq({tag, "_done"}, 32'(done), 32'(0));
  endtask

  initial begin
    int w0, f0;
    logic [2:0]  p;
    logic [17:0] dat;
    int          cut;

    rst = 1'b1;
    sen = 1'b1;
    sd  = 1'b0;
    #3;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    // Single frame, plane 5, alternating data starting with 1 at index 17.
    w0 = n_wr; f0 = n_fd;
    send_frame(3'd5, 18'h2AAAA, 21);
    idle(2);
    chk_eq("single_writes", 32'(n_wr - w0), 32'(18));
    chk_eq("single_fd", 32'(n_fd - f0), 32'(1));
    chk_eq("single_q_empty", 32'(exp_q.size()), 32'(0));

    // Abort plane 2 after 5 data bits, then a full plane 6 frame.
    w0 = n_wr; f0 = n_fd;
    send_frame(3'd2, 18'($urandom), 8);
    chk_eq("abort_writes", 32'(n_wr - w0), 32'(5));
    chk_eq("abort_fd", 32'(n_fd - f0), 32'(0));
    send_frame(3'd6, 18'($urandom), 21);
    idle(1);
    chk_eq("after_abort_writes", 32'(n_wr - w0), 32'(23));
    chk_eq("abort_q_empty", 32'(exp_q.size()), 32'(0));

    // Eight back-to-back frames, planes 0..7, plane number replicated as data.
    w0 = n_wr; f0 = n_fd;
    for (int pl = 0; pl < 8; pl++) begin
      p = 3'(pl);
      send_frame(p, {6{p}}, 21);
    end
    chk_eq("burst_writes", 32'(n_wr - w0), 32'(144));
    chk_eq("burst_fd", 32'(n_fd - f0), 32'(8));
    chk_eq("burst_last_a", 32'(rb2_a), 32'(8'hE0));
    chk_eq("burst_done", 32'(done), 32'(1));
    idle(3);

    // Plane 0 after done: still written, done stays high.
    w0 = n_wr;
    send_frame(3'd0, 18'($urandom), 21);
    idle(2);
    chk_eq("postdone_writes", 32'(n_wr - w0), 32'(18));
    chk_eq("postdone_done", 32'(done), 32'(1));

    // Async reset while plane 1 is writing index 9.
    send_bits(3'd1, 18'($urandom), 12);
    chk_eq("rst_pre_a", 32'(rb2_a), 32'(8'h29));
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    exp_q.delete();
    model_done = 1'b0;
    cur_done   = 1'b0;
    @(negedge clk);
    sen = 1'b1;
    rst = 1'b0;
    idle(1);
    w0 = n_wr;
    send_frame(3'd1, 18'($urandom), 21);
    chk_eq("post_rst_writes", 32'(n_wr - w0), 32'(18));

    // Idle stretch with sd toggling, then a frame.
    w0 = n_wr;
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'(i));
    chk_eq("idle_writes", 32'(n_wr - w0), 32'(0));
    send_frame(3'($urandom), 18'($urandom), 21);
    chk_eq("idle_frame_writes", 32'(n_wr - w0), 32'(18));

    // Random frames, random aborts and gaps.
    for (int f = 0; f < 40; f++) begin
      p   = 3'($urandom_range(0, 7));
      dat = 18'($urandom);
      cut = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : 21;
      send_frame(p, dat, cut);
      idle(int'($urandom_range(0, 2)));
    end
    idle(2);
    chk_eq("final_q_empty", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
